// File: rtl/ring_row_tuner.sv
// Ring-resonator row tuner: sweeps each ring's heater DAC in index order,
// locks onto the drop-port power peak, and commits the best code per ring.

module ring_lane #(
    parameter int CODE_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  clr,
    input  logic                  code_we,
    input  logic [CODE_WIDTH-1:0] code_d,
    input  logic                  lock_we,
    input  logic                  lock_d,
    output logic [CODE_WIDTH-1:0] code,
    output logic                  locked
);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            code   <= '0;
            locked <= 1'b0;
        end else if (clr) begin
            code   <= '0;
            locked <= 1'b0;
        end else begin
            if (code_we) code <= code_d;
            if (lock_we) locked <= lock_d;
        end
    end
endmodule

module ring_row_tuner #(
    parameter int NUM_CHANNEL   = 8,
    parameter int CODE_WIDTH    = 8,
    parameter int PWR_WIDTH     = 10,
    parameter int CODE_STEP     = 1,
    parameter int SETTLE_CYCLES = 4,
    localparam int CH_W = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_start,
    input  logic [NUM_CHANNEL-1:0][PWR_WIDTH-1:0] i_pwr_code,
    input  logic [PWR_WIDTH-1:0]                  i_pwr_thresh,
    output logic [NUM_CHANNEL-1:0][CODE_WIDTH-1:0] o_tune_code,
    output logic [NUM_CHANNEL-1:0]                o_locked,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic [CH_W-1:0]                       o_active_ch
);
    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CODE_WIDTH:0] CODE_MAX  = (CODE_WIDTH+1)'((1 << CODE_WIDTH) - 1);
    localparam logic [CODE_WIDTH:0] STEP_EXT  = (CODE_WIDTH+1)'(CODE_STEP);
    localparam logic [SC_W-1:0]     SETTLE_LD = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [CH_W-1:0]     LAST_CH   = CH_W'(NUM_CHANNEL - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, COMMIT, DONE} state_t;

    state_t                state, state_nx;
    logic [CH_W-1:0]       ch;
    logic [CODE_WIDTH-1:0] code;
    logic [SC_W-1:0]       cnt;
    logic [PWR_WIDTH-1:0]  best_pwr;
    logic [CODE_WIDTH-1:0] best_code;
    logic                  have_best;

    logic [PWR_WIDTH-1:0]  pwr_sel;
    logic [CODE_WIDTH:0]   code_nx;
    logic                  last_pt, last_ch, take, start_ok;

    assign pwr_sel  = i_pwr_code[ch];
    // one extra bit so the step past the top code is seen, not wrapped
    assign code_nx  = {1'b0, code} + STEP_EXT;
    assign last_pt  = code_nx > CODE_MAX;
    assign last_ch  = ch == LAST_CH;
    assign take     = !have_best || (pwr_sel > best_pwr);
    assign start_ok = (state == IDLE) && i_start;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (i_start) state_nx = SETTLE;
            SETTLE:  if (cnt == '0) state_nx = SAMPLE;
            SAMPLE:  state_nx = last_pt ? COMMIT : SETTLE;
            COMMIT:  state_nx = last_ch ? DONE : SETTLE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ch        <= '0;
            code      <= '0;
            cnt       <= '0;
            best_pwr  <= '0;
            best_code <= '0;
            have_best <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (i_start) begin
                    ch        <= '0;
                    code      <= '0;
                    cnt       <= SETTLE_LD;
                    best_pwr  <= '0;
                    best_code <= '0;
                    have_best <= 1'b0;
                end
                SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
                SAMPLE: begin
                    // strict compare: ties keep the lower code
                    if (take) begin
                        best_pwr  <= pwr_sel;
                        best_code <= code;
                    end
                    have_best <= 1'b1;
                    if (!last_pt) begin
                        code <= code_nx[CODE_WIDTH-1:0];
                        cnt  <= SETTLE_LD;
                    end
                end
                COMMIT: if (!last_ch) begin
                    ch        <= ch + 1'b1;
                    code      <= '0;
                    cnt       <= SETTLE_LD;
                    best_pwr  <= '0;
                    best_code <= '0;
                    have_best <= 1'b0;
                end
                DONE:    ch <= '0;
                default: ;
            endcase
        end
    end

    logic                  sweep_we, commit_we;
    logic [CODE_WIDTH-1:0] lane_code_d;
    logic                  lane_lock_d;

    assign sweep_we    = (state == SAMPLE) && !last_pt;
    assign commit_we   = state == COMMIT;
    assign lane_code_d = commit_we ? best_code : code_nx[CODE_WIDTH-1:0];
    assign lane_lock_d = best_pwr >= i_pwr_thresh;

    for (genvar g = 0; g < NUM_CHANNEL; g++) begin : g_lane
        logic sel;
        assign sel = ch == CH_W'(g);
        ring_lane #(.CODE_WIDTH(CODE_WIDTH)) u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .clr     (start_ok),
            .code_we (sel && (sweep_we || commit_we)),
            .code_d  (lane_code_d),
            .lock_we (sel && commit_we),
            .lock_d  (lane_lock_d),
            .code    (o_tune_code[g]),
            .locked  (o_locked[g])
        );
    end

    assign o_busy      = state != IDLE;
    assign o_done      = state == DONE;
    assign o_active_ch = ch;
endmodule

// File: tb/tb_ring_row_tuner.sv
// Scoreboarded bench: a peak-search reference model predicts codes, locks and
// run length; monitors check them whenever a tuner raises o_done.

module tb_ring_row_tuner;
    localparam int NCH = 2;
    localparam int CW  = 4;
    localparam int PW  = 10;

    typedef struct {
        logic [NCH-1:0][CW-1:0] code;
        logic [NCH-1:0]         lock;
        int                     start;
        int                     lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // A: step 4, settle 2; B: step 5 (non-dividing), settle 1
    logic                   start_a, start_b;
    logic [NCH-1:0][PW-1:0] pwr_a, pwr_b;
    logic [PW-1:0]          thr_a, thr_b;
    logic [NCH-1:0][CW-1:0] tune_a, tune_b;
    logic [NCH-1:0]         lock_a, lock_b;
    logic                   busy_a, busy_b, done_a, done_b;
    logic [0:0]             act_a, act_b;
    logic [PW-1:0]          tab_a [NCH][16];
    logic [PW-1:0]          tab_b [NCH][16];

    // ring response: power seen depends on the code currently on that ring
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            pwr_a[c] = tab_a[c][tune_a[c]];
            pwr_b[c] = tab_b[c][tune_b[c]];
        end
    end

    ring_row_tuner #(.NUM_CHANNEL(NCH), .CODE_WIDTH(CW), .PWR_WIDTH(PW),
                     .CODE_STEP(4), .SETTLE_CYCLES(2)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_pwr_code(pwr_a),
        .i_pwr_thresh(thr_a), .o_tune_code(tune_a), .o_locked(lock_a),
        .o_busy(busy_a), .o_done(done_a), .o_active_ch(act_a));

    ring_row_tuner #(.NUM_CHANNEL(NCH), .CODE_WIDTH(CW), .PWR_WIDTH(PW),
                     .CODE_STEP(5), .SETTLE_CYCLES(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_pwr_code(pwr_b),
        .i_pwr_thresh(thr_b), .o_tune_code(tune_b), .o_locked(lock_b),
        .o_busy(busy_b), .o_done(done_b), .o_active_ch(act_b));

    int   tests = 0, fails = 0;
    exp_t q_a[$], q_b[$];
    exp_t ea, eb;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Peak search over the sweep grid; first strict maximum wins.
    function automatic exp_t model(input logic [PW-1:0] tab [NCH][16],
                                   input int thresh, input int step, input int settle);
        exp_t e;
        int   best, bc, n;
        for (int c = 0; c < NCH; c++) begin
            best = -1;
            bc   = 0;
            for (int p = 0; p < 16; p += step)
                if (int'(tab[c][p]) > best) begin
                    best = int'(tab[c][p]);
                    bc   = p;
                end
            e.code[c] = CW'(bc);
            e.lock[c] = best >= thresh;
        end
        n     = 15 / step + 1;
        e.lat = NCH * (n * (settle + 1) + 1);
        e.start = 0;
        return e;
    endfunction

    always @(negedge clk) if (rst_n) begin
        if (busy_a && q_a.size() > 0)
            for (int c = 0; c < NCH; c++)
                if (c < int'(act_a)) check("a_hold_committed", tune_a[c], q_a[0].code[c]);
        if (done_a) begin
            if (q_a.size() == 0) begin
                tests++; fails++;
                $display("FAIL a_unexpected_done: actual 1 required 0");
            end else begin
                ea = q_a.pop_front();
                for (int c = 0; c < NCH; c++) check("a_code", tune_a[c], ea.code[c]);
                check("a_locked", lock_a, ea.lock);
                check("a_latency", cyc - ea.start, ea.lat);
            end
        end
    end

    always @(negedge clk) if (rst_n) begin
        if (done_b) begin
            if (q_b.size() == 0) begin
                tests++; fails++;
                $display("FAIL b_unexpected_done: actual 1 required 0");
            end else begin
                eb = q_b.pop_front();
                for (int c = 0; c < NCH; c++) check("b_code", tune_b[c], eb.code[c]);
                check("b_locked", lock_b, eb.lock);
                check("b_latency", cyc - eb.start, eb.lat);
            end
        end
    end

    // mode 1: pulse start during ch1 SETTLE; it must be ignored
    task automatic run_a(input int thresh, input int mode);
        exp_t e;
        thr_a = PW'(thresh);
        e = model(tab_a, thresh, 4, 2);
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        e.start = cyc;
        q_a.push_back(e);
        check("a_clear_on_start_code", tune_a, 0);
        check("a_clear_on_start_lock", lock_a, 0);
        check("a_busy_after_start", busy_a, 1);
        if (mode == 1) begin
            repeat (13) @(negedge clk);
            check("a_in_ch1", act_a, 1);
            start_a = 1'b1;
            @(negedge clk) start_a = 1'b0;
        end
        for (int i = 0; i < 200 && q_a.size() != 0; i++) @(negedge clk);
        check("a_done_timeout", q_a.size(), 0);
        repeat (4) @(negedge clk);
        check("a_idle_active_ch", act_a, 0);
    endtask

    task automatic run_b(input int thresh);
        exp_t e;
        thr_b = PW'(thresh);
        e = model(tab_b, thresh, 5, 1);
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        e.start = cyc;
        q_b.push_back(e);
        for (int i = 0; i < 200 && q_b.size() != 0; i++) @(negedge clk);
        check("b_done_timeout", q_b.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic fill_rand(input int which);
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 16; k++)
                if (which == 0) tab_a[c][k] = PW'($urandom_range(0, 7) * 100);
                else            tab_b[c][k] = PW'($urandom_range(0, 7) * 100);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; thr_a = '0; thr_b = '0;
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 16; k++) begin
                tab_a[c][k] = PW'(10);
                tab_b[c][k] = PW'(10);
            end
        repeat (2) @(negedge clk);
        check("rst_code", tune_a, 0);
        check("rst_lock", lock_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_active", act_a, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single peak per ring
        tab_a[0][8] = PW'(900);
        tab_a[1][4] = PW'(500);
        run_a(400, 0);
        check("peak_code0", tune_a[0], 8);
        check("peak_code1", tune_a[1], 4);
        check("peak_locked", lock_a, 3);

        // tie at codes 4 and 12, threshold exactly at / just above peak
        for (int k = 0; k < 16; k++) tab_a[0][k] = PW'(10);
        tab_a[0][4]  = PW'(300);
        tab_a[0][12] = PW'(300);
        run_a(300, 0);
        check("tie_code", tune_a[0], 4);
        check("tie_locked_eq", lock_a[0], 1);
        run_a(301, 0);
        check("tie_locked_above", lock_a[0], 0);

        // start while busy is ignored
        fill_rand(0);
        run_a(int'($urandom_range(0, 700)), 1);

        // back-to-back restarts with random rows
        for (int r = 0; r < 6; r++) begin
            fill_rand(0);
            run_a(int'($urandom_range(0, 700)), 0);
        end

        // reset mid-sweep of ch1
        fill_rand(0);
        thr_a = PW'(200);
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (16) @(negedge clk);
        check("pre_rst_in_ch1", act_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_code", tune_a, 0);
        check("mid_rst_lock", lock_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        check("mid_rst_active", act_a, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", busy_a, 0);
        fill_rand(0);
        run_a(int'($urandom_range(0, 700)), 0);

        // sweep grid 0,5,10,15 only: off-grid codes carry larger power
        for (int k = 0; k < 16; k++) tab_b[0][k] = PW'(1000);
        tab_b[0][0] = PW'(100); tab_b[0][5] = PW'(100);
        tab_b[0][10] = PW'(100); tab_b[0][15] = PW'(800);
        for (int k = 0; k < 16; k++) tab_b[1][k] = PW'(1000);
        tab_b[1][0] = PW'(50); tab_b[1][5] = PW'(600);
        tab_b[1][10] = PW'(600); tab_b[1][15] = PW'(20);
        run_b(500);
        check("grid_peak15", tune_b[0], 15);
        check("grid_tie5", tune_b[1], 5);
        check("grid_locked", lock_b, 3);
        for (int r = 0; r < 3; r++) begin
            fill_rand(1);
            run_b(int'($urandom_range(0, 700)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
